// File: rtl/pipe_pkg.sv
// Shared types and latencies for the pipeline issue scoreboard.
// Macro PIPE_SCOREBOARD_FORWARD_EN selects the bypassed-pipeline latencies.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 32;
    localparam int ALU_LAT    = 2;
    localparam int LOAD_LAT   = 2;
    localparam int FWD_LD_LAT = 1;
    localparam int CNT_W      = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    // Cycles a freshly issued writer keeps its destination unreadable.
    function automatic cnt_t issue_lat(input logic is_load);
`ifdef PIPE_SCOREBOARD_FORWARD_EN
        return is_load ? cnt_t'(FWD_LD_LAT) : cnt_t'(0);
`else
        return is_load ? cnt_t'(LOAD_LAT) : cnt_t'(ALU_LAT);
`endif
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: countdown of cycles until its register is readable.
// A new writer can only extend the window, never shorten it.
module sb_entry
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  cnt_t lat,
    output logic busy
);

    cnt_t cnt_q;
    cnt_t cnt_dec;
    cnt_t cnt_d;

    always_comb begin
        cnt_dec = (cnt_q == '0) ? '0 : cnt_q - cnt_t'(1);
        cnt_d   = cnt_dec;
        if (load && (lat > cnt_dec)) begin
            cnt_d = lat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_scoreboard.sv
// Scoreboard issue controller: stalls ID while a used source has a pending write.
// Macro PIPE_SCOREBOARD_FORWARD_EN (see pipe_pkg) shortens the writer windows.
module pipe_scoreboard
    import pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  bubble_sel,
    output logic [NREGS-1:0]      busy_mask,
    output logic [15:0]           stall_cycles
);

    logic [NREGS-1:0] busy;
    logic             hit1;
    logic             hit2;
    logic             stall;
    logic             issue;
    cnt_t             lat;
    logic [15:0]      stall_cnt_q;

    // Handshake: ID offers an instruction with id_valid; it is accepted (issued)
    // on an edge where stall=0 and flush=0, otherwise it is held or squashed.
    assign hit1  = id_use_rs1 & (id_rs1 != '0) & busy[id_rs1];
    assign hit2  = id_use_rs2 & (id_rs2 != '0) & busy[id_rs2];
    assign stall = id_valid & ~flush & (hit1 | hit2);
    assign issue = id_valid & ~stall & ~flush;
    assign lat   = issue_lat(id_is_load);

    assign pc_en      = ~stall;
    assign if_id_en   = ~stall;
    assign bubble_sel = stall | flush;

    assign busy[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_entry
        sb_entry u_entry (
            .clk  (clk),
            .rst  (rst),
            .load (issue & id_regwrite & (id_rd == reg_addr_t'(r))),
            .lat  (lat),
            .busy (busy[r])
        );
    end

    assign busy_mask = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Bench for pipe_scoreboard: readiness-time reference model feeding an expected
// queue, with an independent monitor comparing every cycle's outputs.
module tb_pipe_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_is_load;
    logic        flush;
    logic        pc_en;
    logic        if_id_en;
    logic        bubble_sel;
    logic [31:0] busy_mask;
    logic [15:0] stall_cycles;

    always #5 clk = ~clk;

    pipe_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_is_load   (id_is_load),
        .flush        (flush),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .bubble_sel   (bubble_sel),
        .busy_mask    (busy_mask),
        .stall_cycles (stall_cycles)
    );

    int checks = 0;
    int passed = 0;
    logic [50:0] exp_q[$];

    // Reference model: edge index at which each register becomes readable.
    int ready_edge[32];
    int edge_no = 0;
    int model_stalls = 0;
    int alu_lat;
    int load_lat;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
    endtask

    // One ID cycle: drive inputs, predict outputs, advance the model over the edge.
    task automatic cycle(input logic r, input logic v, input int rs1_i, input int rs2_i,
                         input logic u1, input logic u2, input int rd_i,
                         input logic rw, input logic ld, input logic fl);
        logic [31:0] bm;
        logic        h1;
        logic        h2;
        logic        st;
        logic [15:0] sc;
        int          lat;
        @(negedge clk);
        #1;
        rst = r; id_valid = v; id_rs1 = rs1_i[4:0]; id_rs2 = rs2_i[4:0];
        id_use_rs1 = u1; id_use_rs2 = u2; id_rd = rd_i[4:0];
        id_regwrite = rw; id_is_load = ld; flush = fl;
        if (r) begin
            foreach (ready_edge[i]) ready_edge[i] = 0;
            model_stalls = 0;
        end
        bm = '0;
        for (int i = 1; i < 32; i++) bm[i] = (ready_edge[i] > edge_no);
        h1 = u1 && (rs1_i != 0) && bm[rs1_i];
        h2 = u2 && (rs2_i != 0) && bm[rs2_i];
        st = v && !fl && (h1 || h2);
        sc = model_stalls[15:0];
        exp_q.push_back({!st, !st, st || fl, bm, sc});
        if (!r) begin
            if (st && model_stalls < 65535) model_stalls++;
            if (v && !st && !fl && rw && rd_i != 0) begin
                lat = ld ? load_lat : alu_lat;
                if (edge_no + lat + 1 > ready_edge[rd_i]) ready_edge[rd_i] = edge_no + lat + 1;
            end
        end
        edge_no++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: the DUT presents a full output set every cycle.
    initial begin
        logic [50:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_en",        {31'd0, pc_en},      {31'd0, e[50]});
                chk("if_id_en",     {31'd0, if_id_en},   {31'd0, e[49]});
                chk("bubble_sel",   {31'd0, bubble_sel}, {31'd0, e[48]});
                chk("busy_mask",    busy_mask,           e[47:16]);
                chk("stall_cycles", {16'd0, stall_cycles}, {16'd0, e[15:0]});
            end
        end
    end

    initial begin
`ifdef PIPE_SCOREBOARD_FORWARD_EN
        alu_lat = 0; load_lat = 1;
`else
        alu_lat = 2; load_lat = 2;
`endif
        foreach (ready_edge[i]) ready_edge[i] = 0;
        rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_regwrite = 0; id_is_load = 0; flush = 0;

        // Reset with random inputs.
        for (int i = 0; i < 4; i++)
            cycle(1, 1'($urandom), $urandom_range(0, 31), $urandom_range(0, 31),
                  1'($urandom), 1'($urandom), $urandom_range(0, 31),
                  1'($urandom), 1'($urandom), 1'($urandom));
        idle(1);

        // ADD x5 then SUB x6,x5,x1.
        cycle(0, 1, 1, 2, 1, 1, 5, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 5, 1, 1, 1, 6, 1, 0, 0);
        idle(2);

        // LW x7 / ADD x8,x7,x7 then ADD x9 / dependent.
        cycle(0, 1, 0, 0, 0, 0, 7, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 7, 7, 1, 1, 8, 1, 0, 0);
        cycle(0, 1, 1, 2, 1, 1, 9, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 9, 0, 1, 0, 11, 1, 0, 0);
        idle(2);

        // Dependent on pending x5 while flushed.
        cycle(0, 1, 1, 2, 1, 1, 5, 1, 0, 0);
        cycle(0, 1, 5, 5, 1, 1, 12, 1, 0, 1);
        cycle(0, 1, 5, 5, 1, 1, 12, 1, 0, 1);
        cycle(0, 1, 5, 5, 1, 1, 12, 1, 0, 0);
        idle(2);

        // x0 writer and reader back-to-back.
        cycle(0, 1, 1, 1, 1, 1, 0, 1, 1, 0);
        cycle(0, 1, 0, 0, 1, 1, 13, 1, 0, 0);
        idle(2);

        // Reset asserted mid-stall.
        cycle(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
        cycle(0, 1, 5, 0, 1, 0, 14, 1, 0, 0);
        cycle(1, 1, 5, 0, 1, 0, 14, 1, 0, 0);
        cycle(0, 1, 5, 0, 1, 0, 14, 1, 0, 0);
        idle(2);

        // Randomized traffic on a small register window to provoke hazards.
        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  1'($urandom), 1'($urandom), $urandom_range(0, 7),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
        idle(3);

        // Saturation: preload the perf counter just below its ceiling.
        @(posedge clk);
        #2;
        dut.stall_cnt_q = 16'hFFF0;
        model_stalls = 65520;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 0, 0, 0, 0, 10, 1, 1, 0);
            for (int j = 0; j < 3; j++) cycle(0, 1, 10, 10, 1, 1, 0, 0, 0, 0);
        end
        idle(2);

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain got %0d pending exp 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
